// File: rtl/serial_twos_comp_deserializer.sv
// serial_twos_comp_deserializer
//   Receive end of an LSB-first serial two's-complement link whose bit stream
//   arrives already negated. A Mealy complementer re-negates it bit by bit.
//   Bits are copied unchanged up to and including the first 1, and inverted
//   after that. The recovered bits are assembled into a WIDTH-bit word, which
//   is offered on a valid/ready parallel port.
//
//   Optional feature: define OVF_DETECT_EN to build the ovf flag. It marks the
//   word 1 followed by WIDTH-1 zeros, MSB first. Without the macro, ovf is
//   tied to 0.
//
//   WIDTH legal range: 2..32.

module serial_twos_comp_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic             x,
  output logic             z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overrun,
  output logic             ovf
);

  // Counter wide enough to index every bit position 0..WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);

  // IDLE: no word open. PASS: word open, no 1 seen yet. INV: word open,
  // a 1 has been seen, so later bits are inverted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    INV  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] shift_reg;

  logic             start_bit;   // qualified start of a new word
  logic             seen_one;    // complementer is in its inverting phase
  logic             accept;      // the bit on x belongs to a word
  logic [CNT_W-1:0] bit_pos;     // position that the accepted bit lands in
  logic             complete;    // the accepted bit is the word's MSB
  logic [WIDTH-1:0] word;        // shift register with this cycle's bit merged in
  logic             out_free;    // output register can take a word at the next edge
  logic             load;        // completed word is written to out_data

  // State register. An asynchronous reset drops any partial word at once.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A start always re-opens the word, and its first bit
  // picks PASS or INV. Once a word is complete, the FSM returns to IDLE.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      if (complete) begin
        state_next = IDLE;
      end else if (start_bit) begin
        state_next = x ? INV : PASS;
      end else if (x) begin
        state_next = INV;
      end
    end
  end

  // Output and decode logic. The complementer's Mealy output and the
  // bookkeeping for the current bit are decoded here. The first bit of a word
  // always passes through unchanged, even if the previous word left the FSM
  // in INV.
  always_comb begin
    start_bit = in_valid && in_start;
    seen_one  = (state_reg == INV) && !in_start;
    z         = x ^ seen_one;
    accept    = in_valid && (in_start || (state_reg != IDLE));
    bit_pos   = start_bit ? '0 : cnt_reg;
    complete  = accept && (bit_pos == LAST_POS);
  end

  // Each word bit either takes the decoded bit (if this is its position) or
  // keeps its stored value. A start clears the stored value first.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_word
    assign word[gi] = (accept && (bit_pos == CNT_W'(gi))) ? z
                    : (start_bit ? 1'b0 : shift_reg[gi]);
  end

  // Bit counter and shift register. Both hold across in_valid gaps and
  // rewind when a word completes.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      if (complete) begin
        cnt_reg   <= '0;
        shift_reg <= '0;
      end else begin
        cnt_reg   <= bit_pos + CNT_W'(1);
        shift_reg <= word;
      end
    end
  end

  // A word that is being read out in this same cycle frees the output
  // register. So back-to-back words stream with no bubble.
  always_comb begin
    out_free = !out_valid || out_ready;
    load     = complete && out_free;
  end

  // Output register. A completed word that cannot be stored is dropped, and
  // this is reported with a one-cycle overrun pulse.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= complete && !out_free;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef OVF_DETECT_EN
  // The most negative value is the one word whose negation cannot be
  // represented in WIDTH bits.
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_reg;

  // The ovf flag is captured together with out_data and held with it.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ovf_reg <= 1'b0;
    end else if (load) begin
      ovf_reg <= (word == MIN_NEG);
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_twos_comp_deserializer.sv
// Bench for serial_twos_comp_deserializer (WIDTH=8).
// The reference model works on whole serial values. The expected word is the
// arithmetic negation of the received value, mod 2^WIDTH. The expected z is
// x inverted once any earlier bit of the word was 1. The bench also runs
// directed literal checks.

module tb_serial_twos_comp_deserializer;

  localparam int W = 8;

  logic         clk;
  logic         areset_n;
  logic         in_valid;
  logic         in_start;
  logic         x;
  logic         z;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         overrun;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  logic check_en = 1'b0;

  serial_twos_comp_deserializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .in_valid (in_valid),
    .in_start (in_start),
    .x        (x),
    .z        (z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .overrun  (overrun),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic         m_open;
  int           m_cnt;
  logic [W-1:0] m_serial;
  logic         m_out_valid;
  logic [W-1:0] m_out_data;
  logic         m_overrun;
  logic         m_ovf;

  logic         m_st, m_acc, m_done, m_z;
  int           m_pos;
  logic [W-1:0] m_ser_n, m_word;

  always_comb begin
    m_st    = in_valid && in_start;
    m_acc   = in_valid && (in_start || m_open);
    m_pos   = m_st ? 0 : m_cnt;
    m_ser_n = m_st ? '0 : m_serial;
    if (m_acc) m_ser_n[m_pos] = x;
    m_done  = m_acc && (m_pos == W - 1);
    m_word  = W'(0) - m_ser_n;
    m_z     = x ^ (!m_st && m_open && (m_serial != '0));
  end

  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      m_open      <= 1'b0;
      m_cnt       <= 0;
      m_serial    <= '0;
      m_out_valid <= 1'b0;
      m_out_data  <= '0;
      m_overrun   <= 1'b0;
      m_ovf       <= 1'b0;
    end else begin
      m_overrun <= 1'b0;
      if (m_done) begin
        m_open   <= 1'b0;
        m_cnt    <= 0;
        m_serial <= '0;
        if (!m_out_valid || out_ready) begin
          m_out_valid <= 1'b1;
          m_out_data  <= m_word;
`ifdef OVF_DETECT_EN
          m_ovf       <= (m_word == W'(2 ** (W - 1)));
`else
          m_ovf       <= 1'b0;
`endif
        end else begin
          m_overrun <= 1'b1;
        end
      end else begin
        if (m_acc) begin
          m_open   <= 1'b1;
          m_cnt    <= m_pos + 1;
          m_serial <= m_ser_n;
        end
        if (m_out_valid && out_ready) m_out_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (check_en && areset_n) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_out_valid));
      check("cyc_overrun", 32'(overrun), 32'(m_overrun));
      if (m_out_valid) begin
        check("cyc_out_data", 32'(out_data), 32'(m_out_data));
        check("cyc_ovf", 32'(ovf), 32'(m_ovf));
      end
      if (in_valid) check("cyc_z", 32'(z), 32'(m_z));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_start = 1'($urandom_range(0, 1));
      x        = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_start = 1'b0;
  endtask

  task automatic send_bit(input logic start, input logic b, output logic zs);
    in_valid = 1'b1;
    in_start = start;
    x        = b;
    #2;
    zs = z;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] serial, input int gap, output logic [W-1:0] zs);
    logic zb;
    for (int i = 0; i < W; i++) begin
      send_bit(i == 0, serial[i], zb);
      zs[i] = zb;
      if (i != W - 1) idle_cycles(gap);
    end
    $display("word serial=0x%02h gap=%0d z_stream=0x%02h out_valid=%0b out_data=0x%02h overrun=%0b ovf=%0b",
             serial, gap, zs, out_valid, out_data, overrun, ovf);
  endtask

  logic [W-1:0] zs;
  logic         zb;
  logic         exp_ovf_80;

  initial begin
`ifdef OVF_DETECT_EN
    exp_ovf_80 = 1'b1;
`else
    exp_ovf_80 = 1'b0;
`endif
    areset_n  = 1'b0;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    x         = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    #1;
    areset_n = 1'b1;
    check_en = 1'b1;
    idle_cycles(2);

    // 1: serial 0xFD -> 0x03, z stream 1,1,0,...
    send_word(8'hFD, 0, zs);
    check("t1_z_stream", 32'(zs), 32'h03);
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_out_data", 32'(out_data), 32'h03);
    idle_cycles(2);
    check("t1_drained", 32'(out_valid), 32'h0);

    // 2: zero and most-negative words
    send_word(8'h00, 0, zs);
    check("t2_zero_data", 32'(out_data), 32'h00);
    check("t2_zero_ovf", 32'(ovf), 32'h0);
    idle_cycles(1);
    send_word(8'h80, 0, zs);
    check("t2_min_data", 32'(out_data), 32'h80);
    check("t2_min_ovf", 32'(ovf), 32'(exp_ovf_80));
    idle_cycles(2);

    // 3: consumer stalled, two words back to back
    out_ready = 1'b0;
    send_word(8'hFD, 0, zs);
    check("t3_first_valid", 32'(out_valid), 32'h1);
    check("t3_first_data", 32'(out_data), 32'h03);
    check("t3_first_no_overrun", 32'(overrun), 32'h0);
    send_word(8'h01, 0, zs);
    check("t3_overrun_pulse", 32'(overrun), 32'h1);
    check("t3_data_held", 32'(out_data), 32'h03);
    idle_cycles(1);
    check("t3_overrun_single", 32'(overrun), 32'h0);
    out_ready = 1'b1;
    idle_cycles(1);
    check("t3_drained", 32'(out_valid), 32'h0);

    // 4: restart after 4 bits, then 0xFF
    send_bit(1'b1, 1'b1, zb);
    send_bit(1'b0, 1'b0, zb);
    send_bit(1'b0, 1'b1, zb);
    send_bit(1'b0, 1'b1, zb);
    send_word(8'hFF, 0, zs);
    check("t4_valid", 32'(out_valid), 32'h1);
    check("t4_data", 32'(out_data), 32'h01);
    check("t4_no_overrun", 32'(overrun), 32'h0);
    idle_cycles(2);

    // 5: reset mid-word while a word is held
    out_ready = 1'b0;
    send_word(8'h00, 0, zs);
    check("t5_held_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 5; i++) send_bit(i == 0, 1'b1, zb);
    #2;
    areset_n = 1'b0;
    #1;
    check("t5_reset_valid", 32'(out_valid), 32'h0);
    check("t5_reset_data", 32'(out_data), 32'h0);
    @(posedge clk);
    #2;
    areset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'hFE, 0, zs);
    check("t5_data", 32'(out_data), 32'h02);
    check("t5_valid", 32'(out_valid), 32'h1);
    idle_cycles(2);

    // 6: three idle cycles between every bit
    send_word(8'hFD, 3, zs);
    check("t6_valid", 32'(out_valid), 32'h1);
    check("t6_data", 32'(out_data), 32'h03);
    check("t6_z_stream", 32'(zs), 32'h03);
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
